// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, SR/Cause bit positions and exception codes shared by the CP0 slice
package cp0_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam int IE_BIT    = 0;
  localparam int EXL_BIT   = 1;
  localparam int EXC_LSB   = 2;
  localparam int TIMER_BIT = 9;
  localparam int IP_LSB    = 10;
  localparam int TI_BIT    = 30;
  localparam int BD_BIT    = 31;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
endpackage

// File: rtl/cp0_counter.sv
// cp0_counter: prescaled Count, Compare and the sticky timer-pending flag
module cp0_counter #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic pending_q, pending_d, tick;
  always_comb begin
    tick = pre_q == PRE_MAX;
    pre_d = (count_we || tick) ? '0 : pre_q + 1'b1;
    count_d = count_we ? wdata : count_q + {31'b0, tick};
    compare_d = compare_we ? wdata : compare_q;
    // set only on the increment that lands on Compare; a Compare write always clears
    pending_d = !compare_we && (pending_q || (tick && count_q + 32'd1 == compare_q));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      count_q <= '0;
      compare_q <= '1;
      pending_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      count_q <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end
  assign count = count_q;
  assign compare = compare_q;
  assign pending = pending_q;
endmodule

// File: rtl/cp0_timer.sv
// cp0_timer: system-control coprocessor with SR/Cause/EPC/BadVAddr, prescaled Count/Compare timer and exception request
module cp0_timer import cp0_pkg::*; #(
  parameter int          NUM_HWINT = 6,
  parameter int          COUNT_DIV = 1,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0007
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          cp0_in,
  input  logic [4:0]           cp0_a1,
  input  logic [4:0]           cp0_a2,
  input  logic                 cp0_we,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          m_pc,
  input  logic [31:0]          bad_vaddr,
  input  logic                 is_delay,
  input  logic                 exl_clr,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          cp0_out,
  output logic                 timer_irq
);
  localparam logic [31:0] SR_MASK = ({{(32-NUM_HWINT){1'b0}}, {NUM_HWINT{1'b1}}} << IP_LSB)
                                  | (32'd1 << TIMER_BIT) | 32'd3;
  logic [31:0] sr_q, sr_d, epc_q, epc_d, badv_q, badv_d, count, compare, cause;
  logic [NUM_HWINT-1:0] ip_q;
  logic [4:0] exc_q, exc_d;
  logic bd_q, bd_d, pending, int_req, exc_req, wr;
  cp0_counter #(.COUNT_DIV(COUNT_DIV)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr && cp0_a2 == REG_COUNT),
    .compare_we (wr && cp0_a2 == REG_COMPARE),
    .wdata      (cp0_in),
    .count      (count),
    .compare    (compare),
    .pending    (pending)
  );
  always_comb begin
    int_req = |({sr_q[IP_LSB +: NUM_HWINT], sr_q[TIMER_BIT]} & {hw_int, pending}) && sr_q[IE_BIT] && !sr_q[EXL_BIT];
    exc_req = exc_code != EXC_INT && !sr_q[EXL_BIT];
    req = reset && (int_req || exc_req);
    wr = cp0_we && !req;
    sr_d = (wr && cp0_a2 == REG_SR) ? cp0_in & SR_MASK : sr_q;
    sr_d[EXL_BIT] = req || (sr_d[EXL_BIT] && !exl_clr);
    bd_d = req ? is_delay : bd_q;
    exc_d = req ? (int_req ? EXC_INT : exc_code) : exc_q;
    epc_d = req ? (is_delay ? m_pc - 32'd4 : m_pc) : ((wr && cp0_a2 == REG_EPC) ? cp0_in : epc_q);
    badv_d = (req && exc_req && (exc_code == EXC_ADEL || exc_code == EXC_ADES)) ? bad_vaddr : badv_q;
    cause = '0;
    cause[BD_BIT] = bd_q;
    cause[TI_BIT] = pending;
    cause[IP_LSB +: NUM_HWINT] = ip_q;
    cause[TIMER_BIT] = pending;
    cause[EXC_LSB +: 5] = exc_q;
    case (cp0_a1)
      REG_BADVADDR: cp0_out = badv_q;
      REG_COUNT:    cp0_out = count;
      REG_COMPARE:  cp0_out = compare;
      REG_SR:       cp0_out = sr_q;
      REG_CAUSE:    cp0_out = cause;
      REG_EPC:      cp0_out = epc_q;
      REG_PRID:     cp0_out = PRID_VAL;
      default:      cp0_out = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
      epc_q <= '0;
      badv_q <= '0;
      bd_q <= 1'b0;
      exc_q <= '0;
      ip_q <= '0;
    end else begin
      sr_q <= sr_d;
      epc_q <= epc_d;
      badv_q <= badv_d;
      bd_q <= bd_d;
      exc_q <= exc_d;
      ip_q <= hw_int;
    end
  end
  assign epc_out = epc_q;
  assign timer_irq = pending;
endmodule

// File: doc/cp0_timer.md
Name: cp0_timer

Overview:
- Next-generation system-control coprocessor for the P-series pipelined MIPS core. Sits beside the M stage, as the existing CP0 does.
- Holds SR, Cause and EPC, and adds BadVAddr, Count, Compare and a read-only PRId.
- The hardware-interrupt line count is parametrised. An internal prescaled Count/Compare timer raises its own maskable interrupt.
- Produces the single exception/interrupt request (req) that flushes the pipeline and redirects fetch to the handler.

Parameters:
- NUM_HWINT, 6, number of external interrupt lines (1..6); they map to SR/Cause bits [10 +: NUM_HWINT].
- COUNT_DIV, 1, Count increments once every COUNT_DIV clocks (1..256).
- PRID_VAL, 32'h0000_0007, constant returned when reading register 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears while reset=0.
- cp0_in  in  32  mtc0 write data from the GPR.
- cp0_a1  in  5  read register number (mfc0).
- cp0_a2  in  5  write register number (mtc0).
- cp0_we  in  1  mtc0 write enable.
- exc_code  in  5  exception code of the M-stage instruction; 0 means none.
- m_pc  in  32  PC of the M-stage instruction.
- bad_vaddr  in  32  faulting address from the M stage.
- is_delay  in  1  M-stage instruction is in a delay slot.
- exl_clr  in  1  eret in the M stage.
- hw_int  in  NUM_HWINT  external interrupt levels.
- req  out  1  take exception/interrupt this cycle (combinational).
- epc_out  out  32  current EPC.
- cp0_out  out  32  read data for cp0_a1.
- timer_irq  out  1  timer pending flag (Cause bit 9).

Behaviour:
- Reset values:
  - SR=0, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=32'hFFFF_FFFF, prescaler=0.
  - req=0, timer_irq=0.
- SR fields:
  - IM = SR[10 +: NUM_HWINT] and SR[9] (timer mask), EXL = SR[1], IE = SR[0].
  - Unimplemented bits read 0.
- Cause fields:
  - BD = Cause[31], TI = Cause[30] (mirror of bit 9), IP = Cause[10 +: NUM_HWINT], timer pending = Cause[9], ExcCode = Cause[6:2].
- Request logic:
  - int_req = |(IM & IP_now) & IE & !EXL, where IP_now = {hw_int live, timer pending}.
  - exc_req = (exc_code != 0) & !EXL.
  - req = int_req | exc_req.
- On req (at the clock edge):
  - ExcCode = 0 if int_req, else exc_code.
  - EXL = 1, BD = is_delay.
  - EPC = is_delay ? m_pc-4 : m_pc.
  - If exc_req and exc_code is 4 or 5 (AdEL/AdES), BadVAddr = bad_vaddr.
  - Interrupt wins over exception when both are present.
- exl_clr clears EXL. If req is also asserted that cycle, req wins (EXL = 1).
- mtc0 (cp0_we=1), ignored in any cycle where req=1:
  - Reg 12: writes only the IM bits, SR[1] and SR[0].
  - Reg 14: writes EPC.
  - Reg 9: loads Count and clears the prescaler.
  - Reg 11: loads Compare and clears timer pending.
  - Regs 8, 13 and 15 are read-only; writes are ignored.
- Every cycle, Cause IP[hw] is loaded with hw_int (one-cycle delayed view for reads; int_req uses live hw_int).
- Timer prescaler and Count:
  - The prescaler counts 0..COUNT_DIV-1. tick = (prescaler == COUNT_DIV-1), then the prescaler wraps to 0.
  - On tick, Count = Count+1 and wraps 0xFFFF_FFFF→0.
  - A Count write in the same cycle wins over the increment.
- Timer pending:
  - Sets (sticky) when tick and Count+1 == Compare. Edge semantics: a static Count == Compare does not re-set it.
  - Cleared only by a Compare write or reset. A Compare write and a set in the same cycle: the clear wins.
- Read mux (combinational):
  - 8 BadVAddr, 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRID_VAL; all others 0.
  - A read returns the pre-edge value (no write bypass).
- Reset asserted mid-operation clears all state immediately, independent of clk; req drops combinationally.

Decomposition:
- Shared package cp0_pkg:
  - Register numbers (8, 9, 11, 12, 13, 14, 15).
  - SR/Cause bit positions (EXL, IE, BD, TI, TIMER_BIT=9, IP_LSB=10, EXC_LSB=2).
  - Exception codes (INT=0, ADEL=4, ADES=5).
- One sub-module, cp0_counter: the prescaler, Count and Compare, and the timer pending flag.
  - Inputs: write strobes and data, plus reset.
  - Outputs: count, compare, pending.

Test Plan:
- Reset=0 then release: all reads are 0 except Compare=FFFF_FFFF and PRId=7; req=0. Hold 100 cycles with COUNT_DIV=1 → Count=100.
- mtc0 SR=0x0000_0401, hw_int=6'b000001 → req=1 in the same cycle. Next cycle: Cause=0x0000_0400, ExcCode=0, EXL=1, req=0.
- exc_code=4, is_delay=1, m_pc=0x3008, bad_vaddr=0x1235 → EPC=0x3004, BD=1, Cause[6:2]=4, BadVAddr=0x1235.
- COUNT_DIV=4, Count=0, Compare=3, SR=0x0000_0201 → timer_irq rises at clock 12. req=1 when EXL=0. Compare write clears timer_irq next cycle.
- Same cycle req=1 and mtc0 EPC=0xDEAD and exl_clr=1 → EPC=m_pc, EXL=1, write dropped.
- Count=FFFF_FFFF, tick → Count=0, no spurious pending with Compare=5.
